// File: rtl/move_collector_if.sv
// Move-collector bus: square-array control/data plus the outgoing move stream.
// master = collector side, slave = board/consumer side. MOVE_COUNT_EN adds move_count.
interface move_collector_if;
  logic         start;
  logic         busy;
  logic         sq_reset;
  logic [63:0]  sq_done;
  logic [63:0]  sq_empty;
  logic [5:0]   sq_sel;
  logic         sq_rden;
  logic [151:0] sq_data;
  logic         mv_valid;
  logic         mv_ready;
  logic [18:0]  mv_data;
  logic         gen_done;
`ifdef MOVE_COUNT_EN
  logic [7:0]   move_count;
`endif

  modport master (
    input  start, sq_done, sq_empty, sq_data, mv_ready,
    output busy, sq_reset, sq_sel, sq_rden, mv_valid, mv_data, gen_done
`ifdef MOVE_COUNT_EN
    , output move_count
`endif
  );

  modport slave (
    output start, sq_done, sq_empty, sq_data, mv_ready,
    input  busy, sq_reset, sq_sel, sq_rden, mv_valid, mv_data, gen_done
`ifdef MOVE_COUNT_EN
    , input move_count
`endif
  );
endinterface

// File: rtl/move_collector.sv
// Walks the 64 square units, drains each move FIFO word and streams its valid
// 19-bit moves (slot 7 first). MOVE_COUNT_EN adds a saturating move counter.
module move_collector (
  input  logic             clk,
  input  logic             reset,
  move_collector_if.master bus
);
  typedef enum logic [2:0] {IDLE, CLR, WAIT, SCAN, READ, LATCH, EMIT, FIN} state_e;

  state_e         st_q;
  logic [5:0]     idx_q;
  logic [2:0]     slot_q;
  logic [151:0]   word_q;
  logic           clr_cnt_q;
  logic           busy_q;
  logic           sq_reset_q;
  logic           sq_rden_q;
  logic           mv_valid_q;
  logic           gen_done_q;
  logic [18:0]    mv_data_q;
  logic [18:0]    slots [8];
  logic [2:0]     slot_d;
  logic           advance;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      assign slots[gi] = word_q[19*gi +: 19];
    end
  endgenerate

  assign slot_d  = slot_q - 3'd1;
  // An invalid slot (mv_valid low) is consumed without waiting for mv_ready.
  assign advance = !mv_valid_q || bus.mv_ready;

`ifdef MOVE_COUNT_EN
  logic [7:0] count_q;
  assign bus.move_count = count_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= IDLE;
      idx_q      <= 6'd0;
      slot_q     <= 3'd7;
      word_q     <= '0;
      clr_cnt_q  <= 1'b0;
      busy_q     <= 1'b0;
      sq_reset_q <= 1'b0;
      sq_rden_q  <= 1'b0;
      mv_valid_q <= 1'b0;
      gen_done_q <= 1'b0;
      mv_data_q  <= '0;
`ifdef MOVE_COUNT_EN
      count_q    <= 8'd0;
`endif
    end else begin
      sq_rden_q  <= 1'b0;
      gen_done_q <= 1'b0;
      case (st_q)
        IDLE: begin
          if (bus.start) begin
            st_q       <= CLR;
            busy_q     <= 1'b1;
            sq_reset_q <= 1'b1;
            clr_cnt_q  <= 1'b0;
            idx_q      <= 6'd0;
`ifdef MOVE_COUNT_EN
            count_q    <= 8'd0;
`endif
          end
        end
        CLR: begin
          idx_q <= 6'd0;
          if (clr_cnt_q) begin
            st_q       <= WAIT;
            sq_reset_q <= 1'b0;
          end else begin
            clr_cnt_q <= 1'b1;
          end
        end
        WAIT: begin
          if (&bus.sq_done) st_q <= SCAN;
        end
        SCAN: begin
          if (!bus.sq_empty[idx_q]) begin
            st_q      <= READ;
            sq_rden_q <= 1'b1;
          end else if (idx_q == 6'd63) begin
            st_q       <= FIN;
            gen_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        READ: st_q <= LATCH;
        LATCH: begin
          // FIFO q is valid now, one cycle after the read strobe.
          word_q     <= bus.sq_data;
          slot_q     <= 3'd7;
          mv_valid_q <= !bus.sq_data[151];
          mv_data_q  <= bus.sq_data[151:133];
          st_q       <= EMIT;
        end
        EMIT: begin
          if (advance) begin
`ifdef MOVE_COUNT_EN
            if (mv_valid_q && count_q != 8'hFF) count_q <= count_q + 8'd1;
`endif
            if (slot_q == 3'd0) begin
              st_q       <= SCAN;
              slot_q     <= 3'd7;
              mv_valid_q <= 1'b0;
              mv_data_q  <= '0;
            end else begin
              slot_q     <= slot_d;
              mv_valid_q <= !slots[slot_d][18];
              mv_data_q  <= slots[slot_d];
            end
          end
        end
        FIN: begin
          st_q   <= IDLE;
          busy_q <= 1'b0;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.sq_reset = sq_reset_q;
  assign bus.sq_sel   = idx_q;
  assign bus.sq_rden  = sq_rden_q;
  assign bus.mv_valid = mv_valid_q;
  assign bus.mv_data  = mv_data_q;
  assign bus.gen_done = gen_done_q;
endmodule
